// File: rtl/seg7_scan.sv
// seg7_scan -- four-digit time-multiplexed scan controller for a common-anode
// display, feeding a downstream hex-to-7-segment decoder.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   value[15:0]  in   four hex digits, [3:0] is digit 0 (rightmost)
//   load         in   one-cycle strobe, captures value into the pending register
//   lz_suppress  in   1 = blank leading zero digits (digit 0 always shown)
//   enable       in   1 = scan runs, 0 = freeze position and go dark
//   hex[3:0]     out  nibble of the presented digit, for the decoder
//   an_n[3:0]    out  active-low digit enables, an_n[i] drives digit i
//   digit[1:0]   out  index of the presented digit
//   frame_tick   out  one-cycle pulse after each completed frame
//
// Each digit owns DIV cycles; the first BLANK cycles of a slot are dark to
// stop the previous digit ghosting. The displayed value only changes at frame
// boundaries so a frame never mixes old and new digits.
module seg7_scan #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_suppress,
  input  logic        enable,
  output logic [3:0]  hex,
  output logic [3:0]  an_n,
  output logic [1:0]  digit,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_p0;
  logic [1:0]    dig_p0;
  logic [15:0]   pending_p0;
  logic [15:0]   shown_p0;

  logic slot_end;
  logic frame_end;
  logic lit_window;
  logic suppressed;
  logic lit;

  // Digit d is a leading zero when it and every more significant nibble is 0.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
    logic z;
    case (d)
      2'd0:    z = 1'b0;
      2'd1:    z = (v[15:4] == 12'h000);
      2'd2:    z = (v[15:8] == 8'h00);
      default: z = (v[15:12] == 4'h0);
    endcase
    return z;
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] d);
    return v[{d, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] one_cold(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

  assign slot_end  = enable && (cnt_p0 == CNT_LAST);
  assign frame_end = slot_end && (dig_p0 == 2'd3);

  generate
    if (BLANK == 0) begin : g_noblank
      assign lit_window = 1'b1;
    end else begin : g_blank
      assign lit_window = (cnt_p0 >= CW'(BLANK));
    end
  endgenerate

  assign suppressed = lz_suppress && lz_blank(shown_p0, dig_p0);
  assign lit        = enable && lit_window && !suppressed;

  // Stage 0: scan position and value registers.
  // Stage 1: registered decode of the stage-0 state onto the outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_p0     <= '0;
      dig_p0     <= 2'd0;
      pending_p0 <= 16'h0000;
      shown_p0   <= 16'h0000;
      hex        <= 4'h0;
      an_n       <= 4'hF;
      digit      <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      if (load)
        pending_p0 <= value;
      // A load on the boundary edge itself bypasses pending so it is not
      // delayed by a whole frame.
      if (frame_end)
        shown_p0 <= load ? value : pending_p0;
      if (enable) begin
        if (slot_end) begin
          cnt_p0 <= '0;
          dig_p0 <= dig_p0 + 2'd1;
        end else begin
          cnt_p0 <= cnt_p0 + CW'(1);
        end
      end

      hex        <= nibble(shown_p0, dig_p0);
      an_n       <= lit ? one_cold(dig_p0) : 4'hF;
      digit      <= dig_p0;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  hex;
  logic [3:0]  an_n;
  logic [1:0]  digit;
  logic        frame_tick;

  int n_assert = 0;
  int n_fail   = 0;

  seg7_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .Clock(clk),
    .Resetn(rst_n),
    .value(value),
    .load(load),
    .lz_suppress(lz),
    .enable(en),
    .hex(hex),
    .an_n(an_n),
    .digit(digit),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame as a single integer,
  // digit = pos / DIV, slot cycle = pos % DIV.
  int          m_pos   = 0;
  logic [15:0] m_pend  = 16'h0000;
  logic [15:0] m_shown = 16'h0000;
  logic [3:0]  e_hex = 4'h0;
  logic [3:0]  e_an  = 4'hF;
  logic [1:0]  e_dig = 2'd0;
  logic        e_ft  = 1'b0;
  int          md, mc;
  logic [3:0]  mnib;
  bit          mlz, mboundary;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_pend = 16'h0000; m_shown = 16'h0000;
      e_hex = 4'h0; e_an = 4'hF; e_dig = 2'd0; e_ft = 1'b0;
    end else begin
      md = m_pos / DIV;
      mc = m_pos % DIV;
      mnib = 4'((m_shown >> (4 * md)) & 16'hF);
      mlz = lz && (md > 0) && ((m_shown >> (4 * md)) == 16'h0000);
      e_hex = mnib;
      e_dig = 2'(md);
      e_an  = (en && mc >= BLANK && !mlz) ? ~(4'(1) << md) : 4'hF;
      mboundary = en && (m_pos == FRAME - 1);
      e_ft = mboundary;
      if (load) m_pend = value;
      if (mboundary) m_shown = m_pend;
      if (en) m_pos = (m_pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("cmp_hex_rst", hex, 0);
      check("cmp_an_rst", an_n, 4'hF);
      check("cmp_digit_rst", digit, 0);
      check("cmp_ft_rst", frame_tick, 0);
    end else begin
      check("cmp_hex", hex, e_hex);
      check("cmp_an", an_n, e_an);
      check("cmp_digit", digit, e_dig);
      check("cmp_ft", frame_tick, e_ft);
    end
  end

  // Literal frame check: called right after a frame_tick negedge (or reset
  // release); an_tbl holds the lit an_n pattern per slot.
  task automatic check_frame(input logic [15:0] v, input logic [15:0] an_tbl, input string tag);
    int slot, c;
    logic [3:0] xa;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      slot = j / DIV;
      c = j % DIV;
      xa = (c < BLANK) ? 4'hF : an_tbl[slot*4 +: 4];
      check($sformatf("%s_an_j%0d", tag, j), an_n, xa);
      check($sformatf("%s_hex_j%0d", tag, j), hex, v[slot*4 +: 4]);
      check($sformatf("%s_digit_j%0d", tag, j), digit, slot);
      check($sformatf("%s_ft_j%0d", tag, j), frame_tick, (j == FRAME - 1) ? 1 : 0);
    end
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 4 * FRAME);
    check("ft_seen", frame_tick, 1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  int n;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_an", an_n, 4'hF);
    check("rst_hex", hex, 0);
    check("rst_digit", digit, 0);
    check("rst_ft", frame_tick, 0);
    rst_n = 1'b1;
    check_frame(16'h0000, 16'h7BDE, "f0");

    // Mid-frame load: current frame keeps 0000, next shows 1A3F
    repeat (12) @(negedge clk);
    pulse_load(16'h1A3F);
    wait_ft(n);
    check_frame(16'h1A3F, 16'h7BDE, "f1a3f");

    // Leading-zero suppression
    lz = 1'b1;
    repeat (5) @(negedge clk);
    pulse_load(16'h00B0);
    wait_ft(n);
    check_frame(16'h00B0, 16'hFFDE, "lzb0");
    repeat (3) @(negedge clk);
    pulse_load(16'h0000);
    wait_ft(n);
    check_frame(16'h0000, 16'hFFFE, "lz0");

    // Load on the boundary edge itself
    lz = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
    value = 16'h2222;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coinc_ft", frame_tick, 1);
    check_frame(16'h2222, 16'h7BDE, "coinc");

    // Enable gating mid-slot of digit 2
    repeat (20) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("gate_an", an_n, 4'hF);
      check("gate_digit", digit, 2);
      check("gate_ft", frame_tick, 0);
    end
    en = 1'b1;
    wait_ft(n);
    check("gate_resume_cycles", n, 12);

    // Asynchronous reset during a lit slot
    repeat (4) @(negedge clk);
    check("pre_arst_an", an_n, 4'hE);
    check("pre_arst_hex", hex, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", an_n, 4'hF);
    check("arst_hex", hex, 0);
    check("arst_digit", digit, 0);
    check("arst_ft", frame_tick, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 16'h7BDE, "post_arst");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      value = 16'($urandom);
      load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) lz = ~lz;
      en = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    load = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed 4-digit scan controller that sits directly upstream of the hex-to-7-segment decoder.
- Holds a 16-bit value and steps through its four nibbles in turn, presenting the current nibble on hex for the decoder.
- Drives active-low digit enables (an_n) for a common-anode 4-digit display.
- Adds inter-digit blanking against ghosting, optional leading-zero suppression and tear-free value updates at frame boundaries.

Parameters:
DIV, 100000, clock cycles per digit slot (constraint: DIV >= 2).
BLANK, 1000, cycles at the start of each slot with all digits dark (constraint: 0 <= BLANK < DIV; 0 disables blanking).

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  asynchronous active-low reset.
value  in  16  four hex digits; [3:0] is digit 0 (rightmost).
load  in  1  1-cycle strobe; captures value into the pending register.
lz_suppress  in  1  1 = blank leading zero digits.
enable  in  1  1 = scanning runs; 0 = freeze and go dark.
hex  out  4  nibble for the downstream seg7 decoder.
an_n  out  4  active-low digit enables; an_n[i] drives digit i.
digit  out  2  index of the digit currently presented.
frame_tick  out  1  1-cycle pulse per completed frame.

Behaviour:
- Clock and reset: one clock domain (Clock). Reset is asynchronous and active-low (Resetn).
- Reset values, applied immediately and independent of Clock:
  - pending = 0, shown = 0, cnt = 0, digit = 0.
  - hex = 0, an_n = 4'b1111, frame_tick = 0.
  - A load captured before reset is lost.
  - Resetn asserted mid-slot or mid-frame restarts scanning at digit 0, cnt 0.
- Slot counter (cnt, width clog2(DIV)), when enable = 1:
  - Increments each cycle.
  - At cnt = DIV-1 it wraps to 0 and digit advances modulo 4 (0,1,2,3,0...).
- enable = 0:
  - cnt and digit hold.
  - an_n is forced to 4'b1111 from the next edge.
  - Scanning resumes from the held cnt/digit when enable returns to 1.
- Frame boundary: the edge at which digit wraps 3->0 with cnt wrapping.
- Value path:
  - load = 1 at an edge captures value into pending.
  - At a frame boundary, shown <= pending.
  - If load = 1 at the boundary edge itself, shown <= value and pending <= value (the new value is shown from the very next frame).
  - shown never changes mid-frame, so the display does not tear.
- Leading-zero suppression (lz_suppress = 1):
  - Digit i (i = 1..3) is suppressed when shown nibbles i..3 are all zero.
  - Digit 0 is never suppressed, so the value 0 displays "0".
  - lz_suppress is sampled continuously; a change takes effect from the next slot decode.
- Output decode:
  - Registered, with a fixed one-cycle latency from the (digit, cnt, shown) state.
  - hex = shown nibble [4*digit+3 : 4*digit], regardless of blanking.
  - an_n[digit] = 0 iff enable = 1 AND cnt >= BLANK AND digit is not suppressed; all other an_n bits = 1.
  - At most one an_n bit is low in any cycle.
  - The digit output is registered with hex/an_n, so all three are mutually consistent.
- frame_tick:
  - Asserted for exactly the one cycle after each frame boundary edge (same edge that updates shown, plus register latency).
  - Period = 4*DIV cycles while enable = 1.
  - Never asserted while enable = 0.
- Arithmetic: all counters are unsigned; no saturation; wrap only as specified.
- Outputs are glitch-free, since all outputs come straight from flip-flops.

Test Plan:
- Reset: DIV=8, BLANK=2, Resetn=0 -> an_n=1111, hex=0, digit=0, frame_tick=0; then release with enable=1, no load -> frame 0 shows 0000 (lz_suppress=0), each digit low 6 of 8 cycles.
- Load 16'h1A3F mid-frame, lz_suppress=0:
  - Rest of the current frame still shows 0000.
  - After frame_tick, slots show hex F,3,A,1 with an_n 1110,1101,1011,0111.
  - Each slot has 2 dark cycles then 6 lit cycles.
- Leading-zero suppression: load 16'h00B0, lz_suppress=1 -> digit 0 shows 0 (an_n=1110), digit 1 shows B (1101), digits 2 and 3 stay an_n=1111. Then load 16'h0000 -> only digit 0 lit showing 0.
- Load coincident with the frame boundary edge: value 16'h2222 -> shown = 2222 from the next frame; pending holds 2222. frame_tick period measured at exactly 32 cycles.
- Enable gating: drop enable for 5 cycles mid-slot of digit 2 -> an_n=1111, digit stays 2, no frame_tick; on resume, the slot completes its remaining cycles, then digit 3.
- Asynchronous reset mid-operation: assert Resetn between clock edges during a lit slot -> an_n=1111 and hex=0 immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 and shown=0.
